// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit with a register-bank write-back port.
// A multiply or divide takes 32 RUN cycles. A divide by zero returns its result without iterating.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [IDX_W-1:0] dest_reg,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [IDX_W-1:0] write_port,
    output logic             write
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   b_q;
    logic [IDX_W-1:0]   dest_q;
    logic [CNT_W-1:0]   count;
    // hi holds the product high word or the remainder.
    // lo holds the product low word or the quotient.
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   hi_nx, lo_nx;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
    logic               rem_ge;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
        rem_sh   = {hi, lo[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, b_q});
        rem_diff = rem_sh - {1'b0, b_q};
        if (op_q[1]) begin
            hi_nx = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            lo_nx = {lo[WIDTH-2:0], rem_ge};
        end else begin
            hi_nx = mul_sum[WIDTH:1];
            lo_nx = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    assign busy  = (state != IDLE);
    assign write = done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_q       <= '0;
            b_q        <= '0;
            dest_q     <= '0;
            count      <= '0;
            hi         <= '0;
            lo         <= '0;
            done       <= 1'b0;
            result     <= '0;
            write_port <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        b_q    <= operand_b;
                        dest_q <= dest_reg;
                        count  <= CNT_W'(WIDTH - 1);
                        if (op[1] && operand_b == '0) begin
                            // Divide by zero: the quotient is all ones and the remainder is the dividend.
                            hi    <= operand_a;
                            lo    <= '1;
                            state <= DONE;
                        end else begin
                            hi    <= '0;
                            lo    <= operand_a;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    hi    <= hi_nx;
                    lo    <= lo_nx;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        // The result is taken from the next-state values.
                        // The last iteration is written to the same edge that raises done.
                        result     <= op_q[0] ? hi_nx : lo_nx;
                        write_port <= dest_q;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (!done) begin
                        result     <= op_q[0] ? hi : lo;
                        write_port <= dest_q;
                        done       <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit.
// Checks directed and random operations against an arithmetic reference model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b;
    logic [3:0]  dest_reg;
    logic        busy, done, write;
    logic [31:0] result;
    logic [3:0]  write_port;

    int vectors = 0;
    int miscompares = 0;

    mul_div_unit #(.WIDTH(32), .IDX_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .dest_reg(dest_reg),
        .busy(busy), .done(done), .result(result),
        .write_port(write_port), .write(write)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        case (o)
            2'b00: return p[31:0];
            2'b01: return p[63:32];
            2'b10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // poke_at >= 0 raises a competing start request while the unit is busy.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] d, input int poke_at);
        int n;
        int exp_lat;
        logic [31:0] exp;
        exp     = ref_result(o, a, b);
        exp_lat = (o[1] && b == 0) ? 1 : 32;
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b; dest_reg = d;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); operand_a = $urandom; operand_b = $urandom; dest_reg = 4'($urandom);
        check("busy_after_start", busy, 1);
        n = 0;
        while (!done && n < 40) begin
            if (n == poke_at) begin
                start = 1'b1; op = 2'b10; operand_a = 9; operand_b = 3; dest_reg = 7;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check("latency", 64'(n), 64'(exp_lat));
        check("result", result, exp);
        check("write_port", write_port, d);
        check("write", write, 1);
        @(posedge clk); #1;
        check("done_drop", done, 0);
        check("busy_drop", busy, 0);
        check("result_hold", result, exp);
    endtask

    initial begin
        int wcount;
        reset = 1'b0; start = 1'b0; op = '0; operand_a = '0; operand_b = '0; dest_reg = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_write", write, 0);
        check("rst_result", result, 0);
        check("rst_write_port", write_port, 0);
        @(negedge clk); reset = 1'b1;

        issue(2'b00, 7, 6, 3, -1);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, -1);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6, -1);
        issue(2'b10, 100, 7, 1, -1);
        issue(2'b11, 100, 7, 2, -1);
        issue(2'b11, 32'h8000_0000, 1, 0, -1);
        issue(2'b10, 32'h1234, 0, 9, -1);
        issue(2'b11, 32'h1234, 0, 10, -1);
        issue(2'b00, 5, 5, 2, 10);

        // Abort a multiply with reset; no write-back may follow.
        @(negedge clk);
        start = 1'b1; op = 2'b00; operand_a = 3; operand_b = 3; dest_reg = 4;
        @(posedge clk); #1; start = 1'b0;
        repeat (15) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_write", write, 0);
        check("abort_result", result, 0);
        @(negedge clk); reset = 1'b1;
        wcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (write) wcount++;
        end
        check("abort_no_write", 64'(wcount), 0);
        issue(2'b00, 2, 2, 11, -1);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 0;
                1: b = 1;
                2: b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            issue(2'($urandom), a, b, 4'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
